// File: rtl/lfsr_gal_chk.sv
// lfsr_gal_chk: receive-side PRBS checker that self-synchronizes to a right-shifting Galois LFSR stream.
// Define LFSR_GAL_CHK_ERRCOUNT_EN to build the saturating o_errcount; otherwise it is tied to zero.
//   state     | meaning
//   ST_SEARCH | loading received bits, counting consecutive correct predictions
//   ST_LOCKED | flywheeling on own prediction, flagging and windowing errors
module lfsr_gal_chk #(
  parameter int unsigned     LN          = 8,
  parameter logic [LN-1:0]   TAPS        = 8'hb4,
  parameter int unsigned     LOCK_COUNT  = 16,
  parameter int unsigned     WINDOW      = 64,
  parameter int unsigned     LOSS_THRESH = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_ce,
  input  logic        i_bit,
  output logic        o_valid,
  output logic        o_err,
  output logic        o_locked,
  output logic [31:0] o_errcount
);

  localparam int FILL_W  = $clog2(LN + 1);
  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int WIN_W   = $clog2(WINDOW);
  localparam int WERR_W  = $clog2(LOSS_THRESH + 1);

  localparam logic [FILL_W-1:0]  FILL_FULL  = FILL_W'(LN);
  localparam logic [MATCH_W-1:0] MATCH_LOCK = MATCH_W'(LOCK_COUNT);
  localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(WINDOW - 1);
  localparam logic [WERR_W-1:0]  WERR_LOSS  = WERR_W'(LOSS_THRESH);

  typedef enum logic {ST_SEARCH, ST_LOCKED} state_t;

  state_t               state_q, state_d;
  logic [LN-1:0]        hist_q, hist_d;
  logic [FILL_W-1:0]    fill_q, fill_d;
  logic [MATCH_W-1:0]   match_q, match_d;
  logic [WIN_W-1:0]     win_q, win_d;
  logic [WERR_W-1:0]    werr_q, werr_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;

  logic                 pred;
  logic [MATCH_W-1:0]   match_inc;
  logic [WERR_W-1:0]    werr_inc;

  always_comb begin
    pred      = ^(hist_q & TAPS);
    match_inc = match_q + MATCH_W'(1);
    werr_inc  = werr_q + WERR_W'(1);

    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = match_q;
    win_d   = win_q;
    werr_d  = werr_q;
    valid_d = 1'b0;
    err_d   = 1'b0;

    if (i_ce) begin
      case (state_q)
        ST_SEARCH: begin
          hist_d = {hist_q[LN-2:0], i_bit};
          if (fill_q != FILL_FULL) begin
            fill_d = fill_q + FILL_W'(1);
          end else begin
            valid_d = 1'b1;
            // an all-zero history predicts zero forever, so it never counts as a match
            if ((i_bit == pred) && (hist_q != '0)) begin
              match_d = match_inc;
              if (match_inc == MATCH_LOCK) begin
                state_d = ST_LOCKED;
                win_d   = '0;
                werr_d  = '0;
              end
            end else begin
              match_d = '0;
            end
          end
        end

        ST_LOCKED: begin
          hist_d  = {hist_q[LN-2:0], pred};
          valid_d = 1'b1;
          err_d   = i_bit ^ pred;
          // the threshold is tested before the window wrap so the last bit still counts
          if (err_d && (werr_inc >= WERR_LOSS)) begin
            state_d = ST_SEARCH;
            fill_d  = '0;
            match_d = '0;
            win_d   = '0;
            werr_d  = '0;
          end else if (win_q == WIN_LAST) begin
            win_d  = '0;
            werr_d = '0;
          end else begin
            win_d  = win_q + WIN_W'(1);
            werr_d = err_d ? werr_inc : werr_q;
          end
        end

        default: state_d = ST_SEARCH;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_SEARCH;
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= '0;
      win_q   <= '0;
      werr_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      win_q   <= win_d;
      werr_q  <= werr_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign o_valid  = valid_q;
  assign o_err    = err_q;
  assign o_locked = (state_q == ST_LOCKED);

`ifdef LFSR_GAL_CHK_ERRCOUNT_EN
  logic [31:0] errcount_q, errcount_d;

  always_comb begin
    errcount_d = errcount_q;
    if (err_d && (errcount_q != 32'hffff_ffff)) errcount_d = errcount_q + 32'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) errcount_q <= 32'h0;
    else         errcount_q <= errcount_d;
  end

  assign o_errcount = errcount_q;
`else
  assign o_errcount = 32'h0;
`endif

endmodule

// File: tb/tb_lfsr_gal_chk.sv
// Testbench for lfsr_gal_chk: directed stimulus with a due-cycle scoreboard checked by a monitor.
module tb_lfsr_gal_chk;
  localparam logic [7:0] TAPS = 8'hb4;

  logic        clk;
  logic        i_reset;
  logic        i_ce;
  logic        i_bit;
  logic        o_valid;
  logic        o_err;
  logic        o_locked;
  logic [31:0] o_errcount;

  lfsr_gal_chk dut (
    .i_clk      (clk),
    .i_reset    (i_reset),
    .i_ce       (i_ce),
    .i_bit      (i_bit),
    .o_valid    (o_valid),
    .o_err      (o_err),
    .o_locked   (o_locked),
    .o_errcount (o_errcount)
  );

  typedef struct {
    int due;
    bit err;
    bit lock;
  } exp_t;

  exp_t       sb[$];
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  int         exp_errs = 0;
  int         lk = 0;
  logic [7:0] g;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor: every o_valid must line up with the expectation due on this edge
  always @(negedge clk) begin
    exp_t e;
    if (o_valid) begin
      n_chk++;
      if (sb.size() == 0 || sb[0].due != cyc) begin
        n_fail++;
        $display("FAIL valid_unexpected: o_valid=1 at cycle %0d, no expectation due", cyc);
      end else begin
        e = sb.pop_front();
        if (o_err !== e.err || o_locked !== e.lock) begin
          n_fail++;
          $display("FAIL sample cycle %0d: err=%0b locked=%0b, expected err=%0b locked=%0b",
                   cyc, o_err, o_locked, e.err, e.lock);
        end
      end
    end else if (sb.size() > 0 && sb[0].due == cyc) begin
      n_chk++;
      n_fail++;
      $display("FAIL valid_missing: o_valid=0 at cycle %0d, expected 1", cyc);
      void'(sb.pop_front());
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_count();
`ifdef LFSR_GAL_CHK_ERRCOUNT_EN
    return 32'(exp_errs);
`else
    return 32'h0;
`endif
  endfunction

  task automatic send(input bit ce, input bit b, input bit pv, input bit perr, input bit plock);
    exp_t e;
    i_ce  = ce;
    i_bit = b;
    if (ce && pv) begin
      e.due  = cyc + 1;
      e.err  = perr;
      e.lock = plock;
      sb.push_back(e);
      if (perr) exp_errs++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic gen_bit(output bit y);
    y = g[0];
    g = (g >> 1) ^ (y ? TAPS : 8'h00);
  endtask

  task automatic send_gen(input bit flip, input bit pv, input bit perr, input bit plock);
    bit y;
    gen_bit(y);
    send(1'b1, y ^ flip, pv, perr, plock);
  endtask

  // 8 fill bits, then 16 matches; lock appears on the 24th bit's edge
  task automatic search_lock();
    for (int i = 1; i <= 24; i++) send_gen(1'b0, i >= 9, 1'b0, i == 24);
    lk = 0;
  endtask

  task automatic send_locked(input bit flip, input bit plock);
    send_gen(flip, 1'b1, flip, plock);
    lk++;
  endtask

  task automatic align_window();
    while (lk % 64 != 0) send_locked(1'b0, 1'b1);
  endtask

  task automatic do_reset(input string nm);
    i_reset = 1'b1;
    i_ce    = 1'b1;
    i_bit   = 1'b1;
    @(posedge clk);
    #1;
    chk({nm, "_valid"},    32'(o_valid),  32'h0);
    chk({nm, "_err"},      32'(o_err),    32'h0);
    chk({nm, "_locked"},   32'(o_locked), 32'h0);
    chk({nm, "_errcount"}, o_errcount,    32'h0);
    i_reset  = 1'b0;
    i_ce     = 1'b0;
    exp_errs = 0;
  endtask

  initial begin
    int s;
    i_reset = 1'b1;
    i_ce    = 1'b0;
    i_bit   = 1'b0;
    g       = 8'h01;
    repeat (2) @(posedge clk);
    #1;
    do_reset("reset_init");

    // clean lock and long clean run
    search_lock();
    chk("lock_point", 32'(o_locked), 32'h1);
    for (int i = 0; i < 9976; i++) send_locked(1'b0, 1'b1);
    chk("clean_errcount", o_errcount, exp_count());

    // single error
    send_locked(1'b1, 1'b1);
    chk("single_errcount", o_errcount, exp_count());
    for (int i = 0; i < 10; i++) send_locked(1'b0, 1'b1);
    chk("single_locked", 32'(o_locked), 32'h1);

    // 7 errors in one window, then 100 clean
    align_window();
    for (int p = 0; p < 31; p++) send_locked(p % 5 == 0, 1'b1);
    for (int i = 0; i < 100; i++) send_locked(1'b0, 1'b1);
    chk("seven_locked", 32'(o_locked), 32'h1);

    // 7 errors at the tail of one window and 7 at the head of the next
    align_window();
    for (int p = 0; p < 64; p++) send_locked(p >= 57, 1'b1);
    for (int p = 0; p < 64; p++) send_locked(p < 7, 1'b1);
    chk("wrap_locked", 32'(o_locked), 32'h1);
    chk("wrap_errcount", o_errcount, exp_count());

    // 8th error on the last bit of a window drops lock
    align_window();
    for (int p = 0; p < 63; p++) send_locked(p >= 50 && p <= 56, 1'b1);
    send_locked(1'b1, 1'b0);
    chk("loss_locked", 32'(o_locked), 32'h0);
    chk("loss_errcount", o_errcount, exp_count());
    search_lock();
    chk("relock_locked", 32'(o_locked), 32'h1);
    for (int i = 0; i < 20; i++) send_locked(1'b0, 1'b1);

    // reset while locked with i_ce high
    do_reset("reset_locked");
    search_lock();
    for (int i = 0; i < 10; i++) send_locked(1'b0, 1'b1);

    // idle line immunity
    do_reset("reset_idle");
    for (int i = 1; i <= 1000; i++) send(1'b1, 1'b0, i >= 9, 1'b0, 1'b0);
    for (int i = 0; i < 1000; i++) send(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("idle_locked", 32'(o_locked), 32'h0);

    // 30% clock-enable duty: lock point counted in sampled bits
    do_reset("reset_ce");
    g = 8'h01;
    s = 0;
    for (int c = 0; c < 2000 && s < 24; c++) begin
      if ($urandom_range(0, 9) < 3) begin
        s++;
        send_gen(1'b0, s >= 9, 1'b0, s == 24);
      end else begin
        send(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
      end
    end
    chk("ce_sampled", 32'(s), 32'd24);
    chk("ce_locked", 32'(o_locked), 32'h1);
    lk = 0;
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 9) < 3) send_locked(1'b0, 1'b1);
      else send(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
    end

    for (int i = 0; i < 3; i++) send(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sb_drain", 32'(sb.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
